// File: rtl/exp6_mostra_sequencia_if.sv
// Control/memory/display bundle for the sequence playback block.
// The master side drives start/abort and the memory read data; the slave side is the player.
interface exp6_mostra_sequencia_if;
  logic       iniciar;
  logic [3:0] rodada;
  logic       rapido;
  logic       abortar;
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       toca;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  modport master (
    output iniciar, rodada, rapido, abortar, dado_memoria,
    input  endereco, leds, toca, ocupado, pronto, db_estado
  );

  modport slave (
    input  iniciar, rodada, rapido, abortar, dado_memoria,
    output endereco, leds, toca, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/exp6_mostra_sequencia.sv
// Genius sequence playback: walks memory 0..rodada, lighting each move for T_on
// cycles and blanking for T_off cycles, then pulses pronto.
module exp6_mostra_sequencia #(
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500
) (
  input logic                    clock,
  input logic                    reset,
  exp6_mostra_sequencia_if.slave bus
);

  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES);

  localparam logic [TW-1:0] ON_LAST_N  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] ON_LAST_R  = TW'(ON_CYCLES / 2 - 1);
  localparam logic [TW-1:0] OFF_LAST_N = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST_R = TW'(OFF_CYCLES / 2 - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BUSCA   = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    FIM     = 3'd4
  } estado_t;

  estado_t       estado_q,   estado_d;
  logic [3:0]    endereco_q, endereco_d;
  logic [3:0]    rodada_q,   rodada_d;
  logic          rapido_q,   rapido_d;
  logic [3:0]    leds_q,     leds_d;
  logic [TW-1:0] timer_q,    timer_d;
  logic          fim_on;
  logic          fim_off;

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    rodada_d   = rodada_q;
    rapido_d   = rapido_q;
    leds_d     = leds_q;
    timer_d    = timer_q;

    fim_on  = (timer_q == (rapido_q ? ON_LAST_R  : ON_LAST_N));
    fim_off = (timer_q == (rapido_q ? OFF_LAST_R : OFF_LAST_N));

    // Abort overrides everything, including a simultaneous start in OCIOSO.
    if (bus.abortar) begin
      estado_d = OCIOSO;
      timer_d  = '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (bus.iniciar) begin
            rodada_d   = bus.rodada;
            rapido_d   = bus.rapido;
            endereco_d = '0;
            timer_d    = '0;
            estado_d   = BUSCA;
          end
        end
        BUSCA: begin
          leds_d   = bus.dado_memoria;
          timer_d  = '0;
          estado_d = ACESO;
        end
        ACESO: begin
          if (fim_on) begin
            timer_d  = '0;
            estado_d = APAGADO;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        APAGADO: begin
          if (fim_off) begin
            timer_d = '0;
            if (endereco_q == rodada_q) begin
              estado_d = FIM;
            end else begin
              endereco_d = endereco_q + 1'b1;
              estado_d   = BUSCA;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        FIM:     estado_d = OCIOSO;
        default: estado_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      rodada_q   <= '0;
      rapido_q   <= 1'b0;
      leds_q     <= '0;
      timer_q    <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      rodada_q   <= rodada_d;
      rapido_q   <= rapido_d;
      leds_q     <= leds_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.endereco  = endereco_q;
  assign bus.leds      = (estado_q == ACESO) ? leds_q : '0;
  assign bus.toca      = (estado_q == ACESO);
  assign bus.ocupado   = (estado_q != OCIOSO);
  assign bus.pronto    = (estado_q == FIM);
  assign bus.db_estado = estado_q;

endmodule
